// File: rtl/pic_pkg.sv
// Shared types and ICW/OCW bit positions for the 8259-compatible PIC control core.
package pic_pkg;

  typedef enum logic [2:0] {
    WAIT_ICW1,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } init_state_e;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_LTIM = 3;
  localparam int ICW1_SEL  = 4;

  localparam int ICW4_UPM  = 0;
  localparam int ICW4_AEOI = 1;

  localparam int OCW2_R    = 7;
  localparam int OCW3_SEL  = 3;
  localparam int OCW3_RIS  = 0;
  localparam int OCW3_RR   = 1;

endpackage

// File: rtl/pic_edge_detect.sv
// Registered edge detector: compares each input bit against its value on the previous clock.
module pic_edge_detect #(
  parameter int           W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sig,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= RST_VAL;
    else     prev <= sig;
  end

  assign rise = sig & ~prev;
  assign fall = ~sig & prev;

endmodule

// File: rtl/pic_control_unit.sv
// 8259 control core: ICW/OCW decode, INT request and two-pulse INTA_ vector sequencing.
// Define CASCADE_EN to enable ICW3, CAS_IN/CAS_OUT handling and slave ID matching.
module pic_control_unit
  import pic_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       WR_ENABLE,
  input  logic       RD_ENABLE,
  input  logic       A0,
  inout  wire  [7:0] DATA,
  input  logic       INTERNAL_INT,
  input  logic [2:0] IR_NUM,
  input  logic       INTA_,
  input  logic       SP_,
  input  logic [2:0] CAS_IN,
  output logic [2:0] CAS_OUT,
  output logic [7:0] interrupt_mask,
  output logic       INT,
  output logic       AEOI,
  output logic [1:0] INTA_COUNT,
  output logic       R,
  output logic       sngl,
  output logic       LEVEL,
  output logic       RIRR,
  output logic       RISR
);

  init_state_e state, state_nxt;
  logic [1:0]  rise, fall;
  logic        wr_acc, inta_fall, inta_rise;
  logic        icw1_wr, ocw1_wr, ocw2_wr, ocw3_wr;
  logic        ic4, upm;
  logic [4:0]  base;
  logic        vec_sel, vec_drv;

  // Bit 1 tracks INTA_, which idles high; bit 0 tracks WR_ENABLE.
  pic_edge_detect #(.W(2), .RST_VAL(2'b10)) u_edge (
    .clk  (CLK),
    .rst  (RST),
    .sig  ({INTA_, WR_ENABLE}),
    .rise (rise),
    .fall (fall)
  );

  assign wr_acc    = rise[0];
  assign inta_fall = fall[1];
  assign inta_rise = rise[1];

  assign icw1_wr = wr_acc && !A0 && DATA[ICW1_SEL];
  assign ocw1_wr = wr_acc &&  A0 && (state == READY);
  assign ocw2_wr = wr_acc && !A0 && !DATA[ICW1_SEL] && !DATA[OCW3_SEL] && (state == READY);
  assign ocw3_wr = wr_acc && !A0 && !DATA[ICW1_SEL] &&  DATA[OCW3_SEL] && (state == READY);

  always_ff @(posedge CLK) begin
    if (RST) state <= WAIT_ICW1;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (icw1_wr) begin
      state_nxt = WAIT_ICW2;
    end else if (wr_acc && A0) begin
      case (state)
`ifdef CASCADE_EN
        WAIT_ICW2: state_nxt = !sngl ? WAIT_ICW3 : (ic4 ? WAIT_ICW4 : READY);
`else
        WAIT_ICW2: state_nxt = ic4 ? WAIT_ICW4 : READY;
`endif
        WAIT_ICW3: state_nxt = ic4 ? WAIT_ICW4 : READY;
        WAIT_ICW4: state_nxt = READY;
        default:   state_nxt = state;
      endcase
    end
  end

`ifdef CASCADE_EN
  logic [7:0] icw3;

  always_ff @(posedge CLK) begin
    if (RST)                                                     icw3 <= '0;
    else if (!icw1_wr && wr_acc && A0 && (state == WAIT_ICW3))   icw3 <= DATA;
  end

  // Slave answers only to its own ID; a master stays off the bus for IRs that host a slave.
  always_comb begin
    vec_sel = 1'b1;
    if (!sngl) vec_sel = !SP_ ? (CAS_IN == icw3[2:0]) : !icw3[IR_NUM];
  end

  assign CAS_OUT = (SP_ && !sngl && (INTA_COUNT != 2'd0)) ? IR_NUM : 3'd0;

  logic unused_ok;
  assign unused_ok = ^{fall[0], upm};
`else
  assign vec_sel = 1'b1;
  assign CAS_OUT = 3'd0;

  logic unused_ok;
  assign unused_ok = ^{fall[0], upm, SP_, CAS_IN};
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      ic4            <= 1'b0;
      upm            <= 1'b0;
      base           <= '0;
      sngl           <= 1'b0;
      LEVEL          <= 1'b0;
      interrupt_mask <= '0;
      R              <= 1'b0;
      RIRR           <= 1'b0;
      RISR           <= 1'b0;
      AEOI           <= 1'b0;
      INT            <= 1'b0;
      INTA_COUNT     <= 2'd0;
    end else if (icw1_wr) begin
      // ICW1 restarts initialization and aborts any acknowledge in flight.
      ic4            <= DATA[ICW1_IC4];
      sngl           <= DATA[ICW1_SNGL];
      LEVEL          <= DATA[ICW1_LTIM];
      interrupt_mask <= '0;
      R              <= 1'b0;
      RIRR           <= 1'b0;
      RISR           <= 1'b0;
      AEOI           <= 1'b0;
      INT            <= 1'b0;
      INTA_COUNT     <= 2'd0;
    end else begin
      if (wr_acc && A0 && (state == WAIT_ICW2)) base <= DATA[7:3];
      if (wr_acc && A0 && (state == WAIT_ICW4)) begin
        AEOI <= DATA[ICW4_AEOI];
        upm  <= DATA[ICW4_UPM];
      end
      if (ocw1_wr) interrupt_mask <= DATA;
      if (ocw2_wr) R <= DATA[OCW2_R];
      if (ocw3_wr && DATA[OCW3_RR]) begin
        RIRR <= !DATA[OCW3_RIS];
        RISR <=  DATA[OCW3_RIS];
      end

      if (inta_fall && (INTA_COUNT == 2'd0))
        INT <= 1'b0;
      else if ((state == READY) && INTERNAL_INT && (INTA_COUNT == 2'd0))
        INT <= 1'b1;

      if (inta_fall && (INTA_COUNT != 2'd2))
        INTA_COUNT <= INTA_COUNT + 2'd1;
      else if (inta_rise && (INTA_COUNT == 2'd2))
        INTA_COUNT <= 2'd0;
    end
  end

  assign vec_drv = (INTA_COUNT == 2'd2) && !INTA_ && RD_ENABLE && vec_sel;
  assign DATA    = vec_drv ? {base, IR_NUM} : 8'bz;

endmodule

// File: tb/tb_pic_control_unit.sv
// Self-checking bench for pic_control_unit: write table with scoreboard, plus INTA_/reset/cascade sequences.
module tb_pic_control_unit;

  logic       CLK = 1'b0;
  logic       RST, WR_ENABLE, RD_ENABLE, A0, INTERNAL_INT, INTA_, SP_;
  logic [2:0] IR_NUM, CAS_IN, CAS_OUT;
  logic [7:0] interrupt_mask;
  logic       INT, AEOI, R, sngl, LEVEL, RIRR, RISR;
  logic [1:0] INTA_COUNT;
  wire  [7:0] DATA;
  logic [7:0] d_drv;
  logic       d_en;

  assign DATA = d_en ? d_drv : 8'bz;

  always #5 CLK = ~CLK;

  pic_control_unit dut (
    .CLK(CLK), .RST(RST), .WR_ENABLE(WR_ENABLE), .RD_ENABLE(RD_ENABLE), .A0(A0),
    .DATA(DATA), .INTERNAL_INT(INTERNAL_INT), .IR_NUM(IR_NUM), .INTA_(INTA_),
    .SP_(SP_), .CAS_IN(CAS_IN), .CAS_OUT(CAS_OUT), .interrupt_mask(interrupt_mask),
    .INT(INT), .AEOI(AEOI), .INTA_COUNT(INTA_COUNT), .R(R), .sngl(sngl),
    .LEVEL(LEVEL), .RIRR(RIRR), .RISR(RISR)
  );

  typedef struct {
    logic       a0;
    logic [7:0] d;
    logic [7:0] mask;
    logic       r, aeoi, sngl, level, rirr, risr;
    string      name;
  } vec_t;

  typedef struct {
    string       name;
    logic [16:0] exp;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [16:0] obs_now();
    return {interrupt_mask, INT, AEOI, INTA_COUNT, R, sngl, LEVEL, RIRR, RISR};
  endfunction

  function automatic logic [16:0] pack(logic [7:0] m, logic r, logic ae, logic sg,
                                       logic lv, logic rr, logic rs);
    return {m, 1'b0, ae, 2'b00, r, sg, lv, rr, rs};
  endfunction

  function automatic logic undriven();
    return (DATA === 8'bz) || (DATA === 8'h00);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check();
    sb_t e;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk(e.name, 32'(obs_now()), 32'(e.exp));
    end
  endtask

  task automatic add(input logic a0, input logic [7:0] d, input logic [7:0] m, input logic r,
                     input logic ae, input logic sg, input logic lv, input logic rr,
                     input logic rs, input string name);
    vec_t v;
    v.a0 = a0; v.d = d; v.mask = m; v.r = r; v.aeoi = ae; v.sngl = sg;
    v.level = lv; v.rirr = rr; v.risr = rs; v.name = name;
    tbl.push_back(v);
  endtask

  // One WR_ENABLE strobe; expected outputs are queued as it is driven and checked once it lands.
  task automatic wr(input logic a0, input logic [7:0] d, input string name, input logic [16:0] exp);
    sb_t e;
    e.name = name; e.exp = exp;
    @(negedge CLK);
    sbq.push_back(e);
    A0 = a0; d_drv = d; d_en = 1'b1; WR_ENABLE = 1'b1;
    @(negedge CLK);
    WR_ENABLE = 1'b0; d_en = 1'b0;
    sb_check();
  endtask

  task automatic ack(input string name, input logic [2:0] ir, input logic [7:0] vec,
                     input logic drive, input logic [2:0] cas);
    @(negedge CLK);
    IR_NUM = ir; INTERNAL_INT = 1'b1;
    @(negedge CLK);
    chk({name, "_int_set"}, 32'(INT), 32'd1);
    INTA_ = 1'b0;
    @(negedge CLK);
    chk({name, "_int_clr"}, 32'(INT), 32'd0);
    chk({name, "_cnt1"}, 32'(INTA_COUNT), 32'd1);
    chk({name, "_cas1"}, 32'(CAS_OUT), 32'(cas));
    INTERNAL_INT = 1'b0; INTA_ = 1'b1;
    @(negedge CLK);
    INTA_ = 1'b0; RD_ENABLE = 1'b1;
    @(negedge CLK);
    chk({name, "_cnt2"}, 32'(INTA_COUNT), 32'd2);
    chk({name, "_cas2"}, 32'(CAS_OUT), 32'(cas));
    if (drive) chk({name, "_vector"}, 32'(DATA), 32'(vec));
    else       chk({name, "_data_z"}, 32'(undriven()), 32'd1);
    INTA_ = 1'b1; RD_ENABLE = 1'b0;
    @(negedge CLK);
    chk({name, "_cnt0"}, 32'(INTA_COUNT), 32'd0);
    chk({name, "_cas0"}, 32'(CAS_OUT), 32'd0);
    chk({name, "_data_rel"}, 32'(undriven()), 32'd1);
    chk({name, "_int_idle"}, 32'(INT), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; WR_ENABLE = 1'b0; RD_ENABLE = 1'b0; A0 = 1'b0; INTERNAL_INT = 1'b0;
    INTA_ = 1'b1; SP_ = 1'b1; IR_NUM = 3'd0; CAS_IN = 3'd0; d_drv = 8'h00; d_en = 1'b0;

    //   a0    data   mask   r  ae sg lv rr rs  name
    add(1'b0, 8'h13, 8'h00, 0, 0, 1, 0, 0, 0, "icw1_13");
    add(1'b1, 8'hF8, 8'h00, 0, 0, 1, 0, 0, 0, "icw2_f8");
    add(1'b1, 8'h21, 8'h00, 0, 0, 1, 0, 0, 0, "icw4_21");
    add(1'b1, 8'h40, 8'h40, 0, 0, 1, 0, 0, 0, "ocw1_40");
    add(1'b0, 8'hA0, 8'h40, 1, 0, 1, 0, 0, 0, "ocw2_a0");
    add(1'b0, 8'h0B, 8'h40, 1, 0, 1, 0, 0, 1, "ocw3_0b");
    add(1'b0, 8'h0A, 8'h40, 1, 0, 1, 0, 1, 0, "ocw3_0a");
    add(1'b0, 8'h08, 8'h40, 1, 0, 1, 0, 1, 0, "ocw3_08");
    add(1'b0, 8'h20, 8'h40, 0, 0, 1, 0, 1, 0, "ocw2_20");
    add(1'b1, 8'h00, 8'h00, 0, 0, 1, 0, 1, 0, "ocw1_00");
    add(1'b0, 8'h1B, 8'h00, 0, 0, 1, 1, 0, 0, "icw1_1b");
    add(1'b1, 8'h48, 8'h00, 0, 0, 1, 1, 0, 0, "icw2_48");
    add(1'b1, 8'h03, 8'h00, 0, 1, 1, 1, 0, 0, "icw4_03");
    add(1'b1, 8'hFF, 8'hFF, 0, 1, 1, 1, 0, 0, "ocw1_ff");
    add(1'b0, 8'h12, 8'h00, 0, 0, 1, 0, 0, 0, "icw1_12");
    add(1'b1, 8'hF8, 8'h00, 0, 0, 1, 0, 0, 0, "icw2_noicw4");
    add(1'b1, 8'h81, 8'h81, 0, 0, 1, 0, 0, 0, "ocw1_81");

    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("reset_obs", 32'(obs_now()), 32'd0);
    chk("reset_cas", 32'(CAS_OUT), 32'd0);
    chk("reset_data_z", 32'(undriven()), 32'd1);

    foreach (tbl[i])
      wr(tbl[i].a0, tbl[i].d, tbl[i].name,
         pack(tbl[i].mask, tbl[i].r, tbl[i].aeoi, tbl[i].sngl, tbl[i].level,
              tbl[i].rirr, tbl[i].risr));

    // Base 0xF8, IR 2 -> vector 0xFA.
    ack("ack_ir2", 3'd2, 8'hFA, 1'b1, 3'd0);

    // ICW1 in the middle of an acknowledge aborts it.
    @(negedge CLK);
    INTERNAL_INT = 1'b1;
    @(negedge CLK);
    chk("abort_int_set", 32'(INT), 32'd1);
    INTERNAL_INT = 1'b0; INTA_ = 1'b0;
    @(negedge CLK);
    chk("abort_cnt1", 32'(INTA_COUNT), 32'd1);
    INTA_ = 1'b1;
    wr(1'b0, 8'h13, "abort_icw1", pack(8'h00, 0, 0, 1, 0, 0, 0));

    // Reset after ICW2 restores everything and leaves the core waiting for ICW1.
    wr(1'b0, 8'h1B, "pre_rst_icw1", pack(8'h00, 0, 0, 1, 1, 0, 0));
    wr(1'b1, 8'hF8, "pre_rst_icw2", pack(8'h00, 0, 0, 1, 1, 0, 0));
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_obs", 32'(obs_now()), 32'd0);
    chk("rst_cas", 32'(CAS_OUT), 32'd0);
    wr(1'b1, 8'h55, "a0_write_ignored", pack(8'h00, 0, 0, 0, 0, 0, 0));

`ifdef CASCADE_EN
    SP_ = 1'b0;
    wr(1'b0, 8'h11, "casc_icw1", pack(8'h00, 0, 0, 0, 0, 0, 0));
    wr(1'b1, 8'h48, "casc_icw2", pack(8'h00, 0, 0, 0, 0, 0, 0));
    wr(1'b1, 8'h03, "casc_icw3", pack(8'h00, 0, 0, 0, 0, 0, 0));
    wr(1'b1, 8'h01, "casc_icw4", pack(8'h00, 0, 0, 0, 0, 0, 0));
    wr(1'b1, 8'h02, "casc_ocw1", pack(8'h02, 0, 0, 0, 0, 0, 0));
    CAS_IN = 3'd3;
    ack("slave_match", 3'd5, 8'h4D, 1'b1, 3'd0);
    CAS_IN = 3'd1;
    ack("slave_other", 3'd5, 8'h4D, 1'b0, 3'd0);
    // Same ICW3 read as a master slave bitmap (IR0, IR1 host slaves).
    SP_ = 1'b1;
    ack("master_plain", 3'd5, 8'h4D, 1'b1, 3'd5);
    ack("master_slave_ir", 3'd1, 8'h49, 1'b0, 3'd1);
`else
    SP_ = 1'b0;
    wr(1'b0, 8'h11, "nocasc_icw1", pack(8'h00, 0, 0, 0, 0, 0, 0));
    wr(1'b1, 8'h48, "nocasc_icw2", pack(8'h00, 0, 0, 0, 0, 0, 0));
    wr(1'b1, 8'h03, "nocasc_icw4", pack(8'h00, 0, 1, 0, 0, 0, 0));
    wr(1'b1, 8'h02, "nocasc_ocw1", pack(8'h02, 0, 1, 0, 0, 0, 0));
    CAS_IN = 3'd1;
    ack("nocasc_ack", 3'd5, 8'h4D, 1'b1, 3'd0);
`endif

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pic_control_unit.md
# pic_control_unit

Control and sequencing core of the 8259-compatible programmable interrupt controller. Decodes ICW1–ICW4 and OCW1–OCW3 writes from the read/write logic, holds mode and mask state, raises INT to the CPU and runs the two-pulse INTA_ acknowledge, driving the vector onto the data bus. Sits between the read/write logic, the priority resolver (source of INTERNAL_INT/IR_NUM) and the cascade buffer.

## Interface
- No parameters.
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- WR_ENABLE  in  1  write strobe from read/write logic.
- RD_ENABLE  in  1  read strobe from read/write logic.
- A0  in  1  register select.
- DATA  inout  8  data bus; Z unless driving a vector.
- INTERNAL_INT  in  1  pending unmasked request from priority resolver.
- IR_NUM  in  3  number of the winning IR line.
- INTA_  in  1  CPU acknowledge, active low.
- SP_  in  1  1 = master, 0 = slave.
- CAS_IN  in  3  cascade ID from master (slave use).
- CAS_OUT  out  3  cascade ID driven by master.
- interrupt_mask  out  8  OCW1 mask.
- INT  out  1  interrupt request to CPU.
- AEOI  out  1  ICW4 bit 1.
- INTA_COUNT  out  2  acknowledge pulse counter.
- R  out  1  OCW2 rotate bit; 0 = fully nested.
- sngl  out  1  ICW1 bit 1; 0 = cascaded.
- LEVEL  out  1  ICW1 bit 3; 1 = level-triggered.
- RIRR  out  1  OCW3 RR.
- RISR  out  1  OCW3 RIS.

## Operation
- Write accepted on the cycle WR_ENABLE is 1 and was 0 the previous cycle (one write per strobe).
- ICW1: A0=0, D4=1, any state. Latches IC4=D0, sngl=D1, LEVEL=D3; clears mask, R, RIRR, RISR, AEOI; INT=0, INTA_COUNT=0; state → WAIT_ICW2.
- WAIT_ICW2: A0=1 write latches vector base D7..D3; → WAIT_ICW3 if sngl=0, else WAIT_ICW4 if IC4=1, else READY.
- WAIT_ICW3: A0=1 write latches ICW3 (master: slave bitmap; slave: ID D2..D0); → WAIT_ICW4 if IC4, else READY.
- WAIT_ICW4: A0=1 write latches AEOI=D1 (D0 µPM stored, only 8086 mode implemented); → READY.
- READY: A0=1 → OCW1, interrupt_mask=D. A0=0, D4=0, D3=0 → OCW2, R=D7. A0=0, D4=0, D3=1 → OCW3: if D1=1, RIRR=~D0, RISR=D0; else unchanged.
- INT: set in READY when INTERNAL_INT=1 and INTA_COUNT=0; cleared on first INTA_ falling edge.
- INTA_COUNT: 0→1 on first INTA_ falling edge, 1→2 on second; 2→0 on INTA_ rising edge after second pulse.
- Vector: while INTA_COUNT=2, INTA_=0 and RD_ENABLE=1, DATA={base[7:3], IR_NUM}. Slave drives only if CAS_IN equals its ICW3 ID; master in cascade mode with ICW3 bit IR_NUM set does not drive.
- CAS_OUT: master in cascade mode drives IR_NUM from first INTA_ fall until INTA_COUNT returns to 0; else 0.

## Timing
- Reset values: interrupt_mask=0x00, INT=0, AEOI=0, INTA_COUNT=0, R=0, sngl=0, LEVEL=0, RIRR=0, RISR=0, CAS_OUT=0, DATA=Z, state WAIT_ICW1.
- Register writes visible one cycle after the accepting edge.
- INTA_ edges detected via one-cycle registered history; INT falls and INTA_COUNT steps the cycle after the edge is sampled.
- DATA drive is combinational from RD_ENABLE/INTA_/INTA_COUNT.
- ICW1 mid-acknowledge aborts the cycle; RST overrides everything.
- A0=1 write in WAIT_ICW1 ignored.

## Configuration
- CASCADE_EN defined: ICW3 state, CAS_IN/CAS_OUT logic and slave ID match active.
- Not defined: ICW3 skipped even if sngl=0, CAS_OUT tied 0, CAS_IN ignored, vector always driven.

## Structure
- Package pic_pkg: init-state enum (WAIT_ICW1, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY); ICW/OCW bit-position constants.
- One sub-module pic_edge_detect (registered rising/falling detect for WR_ENABLE and INTA_).

## Test plan
- ICW1=0x13, ICW2=0xF8, ICW4=0x21 → sngl=1, LEVEL=0, AEOI=0, state READY, mask=0x00.
- Then IR_NUM=2, INTERNAL_INT=1 → INT=1; first INTA_ pulse → INT=0, INTA_COUNT=1; second pulse with RD_ENABLE=1 → DATA=0xFA, INTA_COUNT=2, back to 0 after INTA_ rises.
- READY, OCW1=0x40 → interrupt_mask=0x40; OCW2=0xA0 → R=1.
- OCW3=0x0B → RISR=1, RIRR=0; OCW3=0x0A → RIRR=1, RISR=0; OCW3=0x08 → unchanged.
- CASCADE_EN, slave (SP_=0), ICW1=0x11, ICW3=0x03: CAS_IN=3 → vector driven; CAS_IN=1 → DATA Z.
- RST=1 after ICW2 → all outputs at reset values; subsequent A0=1 write ignored.
